ticket_vendor_core: RTL and testbench
=====================================

# ticket_vendor_core

Parametrised ticket-vending controller for the lab board. It handles ticket-type selection, quantity selection, coin payment, ticket release and coin-by-coin change return, for N configurable ticket types and a configurable maximum quantity. It sits behind the debounce/onepulse front end and the clock dividers. It drives the 7-segment formatter and LED logic through registered binary status outputs; BCD conversion is done outside this block.

## Interface
- `N_TYPES`, 3: number of ticket types, 1..8.
- `PRICES`, {8'd15, 8'd10, 8'd5}: packed `N_TYPES`×8-bit price table; type i uses bits [8i+7:8i].
- `MAX_QTY`, 3: maximum tickets per purchase, 1..15.
- `MONEY_W`, 8: width of all money values; must hold 255 ≥ max price×`MAX_QTY`+9.
- `RELEASE_TICKS`, 5: ticks spent in RELEASE.
- `BLINK_TICKS`, 1: ticks between toggles of the idle/release blink.
- `TIMEOUT_TICKS`, 30: inactivity limit; used only with `TVM_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle strobe from the seconds divider.
- `sel_valid` in 1, `sel_type` in 3: type-select pulse and selected index.
- `qty_inc` in 1, `qty_dec` in 1: quantity +1 / −1 pulses.
- `confirm` in 1, `cancel` in 1: advance / abort pulses.
- `coin_valid` in 1, `coin_sel` in 2: coin-insert pulse; `coin_sel` 0=1, 1=5, 2=10, 3=ignored.
- `state_o` out 3: current state (package enum).
- `type_o` out 3, `qty_o` out 4: latched type and quantity.
- `total_o`, `paid_o`, `change_o` out MONEY_W: amount due, amount deposited, change still to return.
- `blink_o` out 1: blink phase.
- `release_o` out 1: one-cycle pulse when RELEASE is entered.
- `change_valid` out 1, `change_coin` out 2: one-cycle pulse per returned coin, coded like `coin_sel`.
- `timeout_o` out 1: one-cycle pulse when a timeout fires.

## Operation
- States: IDLE, TYPE, AMOUNT, PAYMENT, RELEASE, CHANGE. An input not listed for the current state is ignored.
- IDLE:
  - `blink_o` toggles every `BLINK_TICKS` ticks.
  - `sel_valid` with `sel_type` < `N_TYPES` → TYPE, latching `type_o`. Out-of-range indices are ignored everywhere.
- TYPE:
  - `sel_valid` relatches the type.
  - `confirm` → AMOUNT with `qty_o`=1.
  - `cancel` → IDLE.
- AMOUNT:
  - `qty_inc` / `qty_dec` change the quantity, saturating at `MAX_QTY` / 1. Both asserted in the same cycle: no change.
  - `confirm` → PAYMENT with `total_o`=price×qty and `paid_o`=0.
  - `cancel` → IDLE.
- PAYMENT:
  - A coin adds its value to `paid_o`.
  - When registered `paid_o` ≥ `total_o` → RELEASE, with `change_o`=`paid_o`−`total_o`.
  - Otherwise `cancel` → CHANGE with `change_o`=`paid_o`, including any coin accepted in the same cycle.
  - Payment complete takes priority over `cancel`.
- RELEASE:
  - `release_o` pulses on entry and `blink_o` runs.
  - After `RELEASE_TICKS` ticks → CHANGE.
- CHANGE:
  - On each tick with `change_o` > 0: emit the largest coin ≤ `change_o` (10, then 5, then 1), pulse `change_valid`, and subtract the coin value.
  - On a tick with `change_o`=0: → IDLE and clear `type_o`, `qty_o`, `total_o` and `paid_o`.
- Arithmetic is unsigned `MONEY_W`. Subtraction never underflows, given the guards above.

## Timing
- All outputs are registered; `rst` asserted anywhere returns the block to reset values on the next edge or immediately (asynchronous).
- Reset values:
  - `state_o`=IDLE, `type_o`=0, `qty_o`=1.
  - `total_o`=0, `paid_o`=0, `change_o`=0.
  - `blink_o`=0, `release_o`=0, `change_valid`=0, `timeout_o`=0.
- An input pulse at edge n updates the state and outputs at edge n+1.
- Payment completion:
  - A coin at edge n makes `paid_o` ≥ `total_o` at edge n+1.
  - RELEASE and `release_o` follow at edge n+2.
- Tick counters are cleared on every state entry.
- CHANGE returning k coins lasts k+1 ticks.

## Configuration
- `TVM_TIMEOUT_EN` defined:
  - An inactivity counter, counting in ticks and cleared by any accepted input pulse, runs in TYPE, AMOUNT and PAYMENT.
  - Reaching `TIMEOUT_TICKS` pulses `timeout_o`. TYPE/AMOUNT → IDLE; PAYMENT → CHANGE with `change_o`=`paid_o`.
- `TVM_TIMEOUT_EN` not defined:
  - The counter is absent and `timeout_o` is tied to 0.
  - The block waits indefinitely.

## Structure
- Package `ticket_vendor_pkg` holds:
  - the state enum;
  - the coin codes and the coin-value function;
  - the default price table constant.
- Sub-module `ticket_change_dispenser` holds the CHANGE-state coin selection and subtraction, with a load/tick interface and a done flag.

## Test plan
- Reset mid-PAYMENT (`paid_o`=7) → all outputs at reset values immediately.
- Type 2 (15), qty 2 → total 30; coins 10, 10, 5, 10 → `paid_o`=35, RELEASE two cycles after the last coin, `release_o` pulse, 5 ticks later CHANGE → one coin code 1 (value 5), next tick → IDLE.
- AMOUNT: `qty_inc` ×5 → qty 3; `qty_dec` ×5 → qty 1; inc and dec in the same cycle → unchanged.
- Type 0 (5), qty 1, coins 1 and 1, then `cancel` together with a 5 coin → CHANGE with 7 → coins 5, 1, 1 on three ticks, IDLE on the fourth.
- In IDLE, `sel_type`=5 with `N_TYPES`=3 → ignored. Exact pay of 10 for type 1 → `change_o`=0, no `change_valid` pulse, IDLE one tick after CHANGE entry.
- With `TVM_TIMEOUT_EN`, `TIMEOUT_TICKS`=4: PAYMENT with `paid_o`=6, no input for 4 ticks → `timeout_o` pulse, refund coins 5 and 1. Without the macro: no timeout after 100 ticks.

Source files
------------

// File: rtl/ticket_vendor_pkg.sv
// ticket_vendor_pkg
// Shared definitions for the ticket vending controller:
//   - state_t        : controller state encoding (also driven on state_o)
//   - COIN_*         : coin codes shared by coin_sel and change_coin
//   - coin_value()   : coin code -> money value (unused code -> 0)
//   - DEFAULT_PRICES : default packed price table, type i at bits [8i+7:8i]
package ticket_vendor_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TYPE    = 3'd1,
        S_AMOUNT  = 3'd2,
        S_PAYMENT = 3'd3,
        S_RELEASE = 3'd4,
        S_CHANGE  = 3'd5
    } state_t;

    localparam logic [1:0] COIN_1    = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_NONE = 2'd3;

    localparam logic [23:0] DEFAULT_PRICES = {8'd15, 8'd10, 8'd5};

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 8'd1;
            COIN_5:  return 8'd5;
            COIN_10: return 8'd10;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/ticket_change_dispenser.sv
// ticket_change_dispenser
// Holds the change still owed and pays it out one coin per step, always
// choosing the largest coin not exceeding the remaining amount (10, 5, 1).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load          : load load_value as the amount owed (wins over step)
//   load_value    : amount to load
//   step          : pay out one coin if anything is owed
//   amount        : registered amount still owed
//   coin_valid    : registered one-cycle pulse per coin paid
//   coin          : registered code of the last coin paid
//   done          : nothing left to pay (combinational from amount)
module ticket_change_dispenser
    import ticket_vendor_pkg::*;
#(
    parameter int unsigned MONEY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MONEY_W-1:0] load_value,
    input  logic               step,
    output logic [MONEY_W-1:0] amount,
    output logic               coin_valid,
    output logic [1:0]         coin,
    output logic               done
);

    logic [1:0] pick;

    // NOTE: every path assigns pick, so this always_comb cannot infer a latch.
    always_comb begin
        if (amount >= MONEY_W'(10)) begin
            pick = COIN_10;
        end else if (amount >= MONEY_W'(5)) begin
            pick = COIN_5;
        end else begin
            pick = COIN_1;
        end
    end

    assign done = (amount == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amount     <= '0;
            coin_valid <= 1'b0;
            coin       <= COIN_1;
        end else begin
            coin_valid <= 1'b0;
            if (load) begin
                amount <= load_value;
            end else if (step && !done) begin
                amount     <= amount - MONEY_W'(coin_value(pick));
                coin_valid <= 1'b1;
                coin       <= pick;
            end
        end
    end

endmodule

// File: rtl/ticket_vendor_core.sv
// ticket_vendor_core
// Ticket vending controller: type selection, quantity selection, coin
// payment, timed ticket release and coin-by-coin change return.
// Optional feature macro: TVM_TIMEOUT_EN (inactivity timeout in TYPE,
// AMOUNT and PAYMENT; when undefined timeout_o is tied to 0).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   tick                     : one-cycle seconds strobe
//   sel_valid, sel_type      : type select pulse and index
//   qty_inc, qty_dec         : quantity +1 / -1 pulses
//   confirm, cancel          : advance / abort pulses
//   coin_valid, coin_sel     : coin insert pulse and coin code
//   state_o, type_o, qty_o   : current state, latched type and quantity
//   total_o, paid_o, change_o: amount due, deposited, still to return
//   blink_o                  : blink phase (IDLE and RELEASE)
//   release_o                : one-cycle pulse on RELEASE entry
//   change_valid, change_coin: one pulse per returned coin
//   timeout_o                : one-cycle pulse when a timeout fires
module ticket_vendor_core
    import ticket_vendor_pkg::*;
#(
    parameter int unsigned          N_TYPES       = 3,
    parameter logic [8*N_TYPES-1:0] PRICES        = DEFAULT_PRICES,
    parameter int unsigned          MAX_QTY       = 3,
    parameter int unsigned          MONEY_W       = 8,
    parameter int unsigned          RELEASE_TICKS = 5,
    parameter int unsigned          BLINK_TICKS   = 1,
    parameter int unsigned          TIMEOUT_TICKS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               sel_valid,
    input  logic [2:0]         sel_type,
    input  logic               qty_inc,
    input  logic               qty_dec,
    input  logic               confirm,
    input  logic               cancel,
    input  logic               coin_valid,
    input  logic [1:0]         coin_sel,
    output logic [2:0]         state_o,
    output logic [2:0]         type_o,
    output logic [3:0]         qty_o,
    output logic [MONEY_W-1:0] total_o,
    output logic [MONEY_W-1:0] paid_o,
    output logic [MONEY_W-1:0] change_o,
    output logic               blink_o,
    output logic               release_o,
    output logic               change_valid,
    output logic [1:0]         change_coin,
    output logic               timeout_o
);

    state_t             state, state_n;
    logic [2:0]         type_n;
    logic [3:0]         qty_n;
    logic [MONEY_W-1:0] total_n, paid_n;
    logic               blink_n, release_n;
    logic [15:0]        blink_cnt, blink_cnt_n, rel_cnt, rel_cnt_n;

    logic               sel_ok, coin_ok, pay_done, to_fire;
    logic [MONEY_W-1:0] price, coin_amt, paid_plus;
    logic               disp_load, disp_step, disp_done;
    logic [MONEY_W-1:0] disp_value;

    assign state_o   = state;
    assign sel_ok    = sel_valid && (32'(sel_type) < N_TYPES);
    assign coin_ok   = coin_valid && (coin_sel != COIN_NONE);
    assign coin_amt  = coin_ok ? MONEY_W'(coin_value(coin_sel)) : '0;
    assign paid_plus = paid_o + coin_amt;
    assign price     = MONEY_W'(PRICES[{type_o, 3'b000} +: 8]);
    // Completion looks at the registered deposit, so it lands one edge after the coin.
    assign pay_done  = (state == S_PAYMENT) && (paid_o >= total_o);

    always_comb begin
        state_n     = state;
        type_n      = type_o;
        qty_n       = qty_o;
        total_n     = total_o;
        paid_n      = paid_o;
        blink_n     = blink_o;
        blink_cnt_n = blink_cnt;
        rel_cnt_n   = rel_cnt;
        release_n   = 1'b0;
        disp_load   = 1'b0;
        disp_value  = '0;
        disp_step   = 1'b0;

        case (state)
            S_IDLE: begin
                if (sel_ok) begin
                    state_n = S_TYPE;
                    type_n  = sel_type;
                end
            end
            S_TYPE: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else if (confirm) begin
                    state_n = S_AMOUNT;
                    qty_n   = 4'd1;
                end else if (sel_ok) begin
                    type_n = sel_type;
                end else if (to_fire) begin
                    state_n = S_IDLE;
                end
            end
            S_AMOUNT: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else if (confirm) begin
                    state_n = S_PAYMENT;
                    total_n = price * MONEY_W'(qty_o);
                    paid_n  = '0;
                end else if (qty_inc && !qty_dec && qty_o < 4'(MAX_QTY)) begin
                    qty_n = qty_o + 4'd1;
                end else if (qty_dec && !qty_inc && qty_o > 4'd1) begin
                    qty_n = qty_o - 4'd1;
                end else if (to_fire) begin
                    state_n = S_IDLE;
                end
            end
            S_PAYMENT: begin
                if (pay_done) begin
                    state_n    = S_RELEASE;
                    release_n  = 1'b1;
                    disp_load  = 1'b1;
                    disp_value = paid_o - total_o;
                end else if (cancel) begin
                    state_n    = S_CHANGE;
                    paid_n     = paid_plus;
                    disp_load  = 1'b1;
                    disp_value = paid_plus;
                end else if (coin_ok) begin
                    paid_n = paid_plus;
                end else if (to_fire) begin
                    state_n    = S_CHANGE;
                    disp_load  = 1'b1;
                    disp_value = paid_o;
                end
            end
            S_RELEASE: begin
                if (tick) begin
                    if (rel_cnt == 16'(RELEASE_TICKS - 1)) begin
                        state_n = S_CHANGE;
                    end else begin
                        rel_cnt_n = rel_cnt + 16'd1;
                    end
                end
            end
            S_CHANGE: begin
                if (tick) begin
                    if (disp_done) begin
                        state_n = S_IDLE;
                        type_n  = '0;
                        qty_n   = '0;
                        total_n = '0;
                        paid_n  = '0;
                    end else begin
                        disp_step = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Blink runs only in IDLE and RELEASE and rests low elsewhere.
        if (state == S_IDLE || state == S_RELEASE) begin
            if (tick) begin
                if (blink_cnt == 16'(BLINK_TICKS - 1)) begin
                    blink_n     = ~blink_o;
                    blink_cnt_n = '0;
                end else begin
                    blink_cnt_n = blink_cnt + 16'd1;
                end
            end
        end else begin
            blink_n = 1'b0;
        end

        if (state_n != state) begin
            blink_cnt_n = '0;
            rel_cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            type_o    <= '0;
            qty_o     <= 4'd1;
            total_o   <= '0;
            paid_o    <= '0;
            blink_o   <= 1'b0;
            release_o <= 1'b0;
            blink_cnt <= '0;
            rel_cnt   <= '0;
        end else begin
            state     <= state_n;
            type_o    <= type_n;
            qty_o     <= qty_n;
            total_o   <= total_n;
            paid_o    <= paid_n;
            blink_o   <= blink_n;
            release_o <= release_n;
            blink_cnt <= blink_cnt_n;
            rel_cnt   <= rel_cnt_n;
        end
    end

`ifdef TVM_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        accepted, watched;

    always_comb begin
        case (state)
            S_TYPE:    accepted = sel_ok | confirm | cancel;
            S_AMOUNT:  accepted = qty_inc | qty_dec | confirm | cancel;
            S_PAYMENT: accepted = coin_ok | cancel;
            default:   accepted = 1'b0;
        endcase
    end

    assign watched = (state == S_TYPE) || (state == S_AMOUNT) || (state == S_PAYMENT);
    // A completed payment moves on by itself, so it never times out.
    assign to_fire = watched && tick && !accepted && !pay_done
                     && (idle_cnt == 16'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= to_fire;
            if (!watched || accepted || state_n != state) begin
                idle_cnt <= '0;
            end else if (tick) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    ticket_change_dispenser #(
        .MONEY_W(MONEY_W)
    ) u_dispenser (
        .clk        (clk),
        .rst        (rst),
        .load       (disp_load),
        .load_value (disp_value),
        .step       (disp_step),
        .amount     (change_o),
        .coin_valid (change_valid),
        .coin       (change_coin),
        .done       (disp_done)
    );

endmodule

// File: tb/tb_ticket_vendor_core.sv
// tb_ticket_vendor_core
// Scenario tasks drive the controller and compare its registered outputs
// inline; returned change coins go through an expected-coin queue that is
// filled when a refund or payout becomes known and drained by a monitor.
module tb_ticket_vendor_core;
    import ticket_vendor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, sel_valid = 1'b0, qty_inc = 1'b0, qty_dec = 1'b0;
    logic       confirm = 1'b0, cancel = 1'b0, coin_valid = 1'b0;
    logic [2:0] sel_type = 3'd0;
    logic [1:0] coin_sel = 2'd0;
    logic [2:0] state_o, type_o;
    logic [3:0] qty_o;
    logic [7:0] total_o, paid_o, change_o;
    logic       blink_o, release_o, change_valid, timeout_o;
    logic [1:0] change_coin;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         coins_seen = 0;
    int         timeouts_seen = 0;
    logic [1:0] exp_q[$];

    ticket_vendor_core #(
        .TIMEOUT_TICKS(4)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .sel_valid(sel_valid), .sel_type(sel_type),
        .qty_inc(qty_inc), .qty_dec(qty_dec),
        .confirm(confirm), .cancel(cancel),
        .coin_valid(coin_valid), .coin_sel(coin_sel),
        .state_o(state_o), .type_o(type_o), .qty_o(qty_o),
        .total_o(total_o), .paid_o(paid_o), .change_o(change_o),
        .blink_o(blink_o), .release_o(release_o),
        .change_valid(change_valid), .change_coin(change_coin),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard side: every returned coin must match the next expected one.
    always @(negedge clk) begin
        logic [1:0] exp_coin;
        if (change_valid) begin
            coins_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL change_coin_unexpected: got code %0d, none expected", change_coin);
            end else begin
                exp_coin = exp_q.pop_front();
                if (change_coin !== exp_coin) begin
                    n_fail++;
                    $display("FAIL change_coin: got code %0d want %0d", change_coin, exp_coin);
                end
            end
        end
        if (timeout_o) timeouts_seen++;
    end

    // Greedy refund model: largest coin first.
    function automatic void push_refund(input int amount);
        int amt = amount;
        while (amt > 0) begin
            if (amt >= 10) begin exp_q.push_back(COIN_10); amt -= 10; end
            else if (amt >= 5) begin exp_q.push_back(COIN_5); amt -= 5; end
            else begin exp_q.push_back(COIN_1); amt -= 1; end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1; cycle(); tick = 1'b0;
    endtask

    task automatic do_sel(input logic [2:0] t);
        sel_valid = 1'b1; sel_type = t; cycle(); sel_valid = 1'b0;
    endtask

    task automatic do_confirm();
        confirm = 1'b1; cycle(); confirm = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; cycle(); cancel = 1'b0;
    endtask

    task automatic do_coin(input logic [1:0] c);
        coin_valid = 1'b1; coin_sel = c; cycle(); coin_valid = 1'b0;
    endtask

    task automatic do_qty(input logic inc, input logic dec);
        qty_inc = inc; qty_dec = dec; cycle(); qty_inc = 1'b0; qty_dec = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        n_tests++; if (state_o !== 3'(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
        n_tests++; if (type_o !== 3'd0) begin n_fail++; $display("FAIL reset_type: got %0d want 0", type_o); end
        n_tests++; if (qty_o !== 4'd1) begin n_fail++; $display("FAIL reset_qty: got %0d want 1", qty_o); end
        n_tests++; if ({total_o, paid_o, change_o} !== 24'd0) begin n_fail++; $display("FAIL reset_money: got %0d/%0d/%0d want 0/0/0", total_o, paid_o, change_o); end
        n_tests++; if ({blink_o, release_o, change_valid, timeout_o} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {blink_o, release_o, change_valid, timeout_o}); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_blink();
        do_tick();
        n_tests++; if (blink_o !== 1'b1) begin n_fail++; $display("FAIL blink_first_tick: got %b want 1", blink_o); end
        do_tick();
        n_tests++; if (blink_o !== 1'b0) begin n_fail++; $display("FAIL blink_second_tick: got %b want 0", blink_o); end
    endtask

    task automatic test_purchase();
        do_sel(3'd2);
        n_tests++; if (state_o !== 3'(S_TYPE) || type_o !== 3'd2) begin n_fail++; $display("FAIL buy_select: got state %0d type %0d want %0d 2", state_o, type_o, S_TYPE); end
        do_confirm();
        n_tests++; if (state_o !== 3'(S_AMOUNT) || qty_o !== 4'd1) begin n_fail++; $display("FAIL buy_amount: got state %0d qty %0d want %0d 1", state_o, qty_o, S_AMOUNT); end
        do_qty(1'b1, 1'b0);
        do_confirm();
        n_tests++; if (state_o !== 3'(S_PAYMENT) || total_o !== 8'd30 || paid_o !== 8'd0) begin n_fail++; $display("FAIL buy_payment: got state %0d total %0d paid %0d want %0d 30 0", state_o, total_o, paid_o, S_PAYMENT); end
        do_coin(COIN_10); do_coin(COIN_10); do_coin(COIN_5);
        n_tests++; if (paid_o !== 8'd25 || state_o !== 3'(S_PAYMENT)) begin n_fail++; $display("FAIL buy_partial: got paid %0d state %0d want 25 %0d", paid_o, state_o, S_PAYMENT); end
        do_coin(COIN_10);
        n_tests++; if (paid_o !== 8'd35 || state_o !== 3'(S_PAYMENT)) begin n_fail++; $display("FAIL buy_paid: got paid %0d state %0d want 35 %0d", paid_o, state_o, S_PAYMENT); end
        cycle();
        push_refund(5);
        n_tests++; if (state_o !== 3'(S_RELEASE) || release_o !== 1'b1 || change_o !== 8'd5) begin n_fail++; $display("FAIL buy_release: got state %0d rel %b change %0d want %0d 1 5", state_o, release_o, change_o, S_RELEASE); end
        cycle();
        n_tests++; if (release_o !== 1'b0) begin n_fail++; $display("FAIL buy_release_pulse: got %b want 0", release_o); end
        repeat (4) do_tick();
        n_tests++; if (state_o !== 3'(S_RELEASE)) begin n_fail++; $display("FAIL buy_release_hold: got %0d want %0d", state_o, S_RELEASE); end
        do_tick();
        n_tests++; if (state_o !== 3'(S_CHANGE)) begin n_fail++; $display("FAIL buy_change_entry: got %0d want %0d", state_o, S_CHANGE); end
        do_tick();
        n_tests++; if (change_o !== 8'd0 || state_o !== 3'(S_CHANGE)) begin n_fail++; $display("FAIL buy_change_coin: got change %0d state %0d want 0 %0d", change_o, state_o, S_CHANGE); end
        do_tick();
        n_tests++; if (state_o !== 3'(S_IDLE) || paid_o !== 8'd0 || total_o !== 8'd0 || type_o !== 3'd0) begin n_fail++; $display("FAIL buy_idle: got state %0d paid %0d total %0d type %0d want %0d 0 0 0", state_o, paid_o, total_o, type_o, S_IDLE); end
    endtask

    task automatic test_amount();
        do_sel(3'd1);
        do_confirm();
        repeat (5) do_qty(1'b1, 1'b0);
        n_tests++; if (qty_o !== 4'd3) begin n_fail++; $display("FAIL qty_saturate_max: got %0d want 3", qty_o); end
        repeat (5) do_qty(1'b0, 1'b1);
        n_tests++; if (qty_o !== 4'd1) begin n_fail++; $display("FAIL qty_saturate_min: got %0d want 1", qty_o); end
        do_qty(1'b1, 1'b0);
        do_qty(1'b1, 1'b1);
        n_tests++; if (qty_o !== 4'd2) begin n_fail++; $display("FAIL qty_both: got %0d want 2", qty_o); end
        do_cancel();
        n_tests++; if (state_o !== 3'(S_IDLE)) begin n_fail++; $display("FAIL amount_cancel: got %0d want %0d", state_o, S_IDLE); end
    endtask

    task automatic test_cancel_refund();
        do_sel(3'd0);
        do_confirm();
        do_confirm();
        do_coin(COIN_1); do_coin(COIN_1);
        n_tests++; if (paid_o !== 8'd2 || total_o !== 8'd5) begin n_fail++; $display("FAIL refund_paid: got paid %0d total %0d want 2 5", paid_o, total_o); end
        coin_valid = 1'b1; coin_sel = COIN_5; cancel = 1'b1;
        cycle();
        coin_valid = 1'b0; cancel = 1'b0;
        push_refund(7);
        n_tests++; if (state_o !== 3'(S_CHANGE) || change_o !== 8'd7) begin n_fail++; $display("FAIL refund_entry: got state %0d change %0d want %0d 7", state_o, change_o, S_CHANGE); end
        repeat (3) do_tick();
        n_tests++; if (state_o !== 3'(S_CHANGE) || change_o !== 8'd0) begin n_fail++; $display("FAIL refund_drain: got state %0d change %0d want %0d 0", state_o, change_o, S_CHANGE); end
        do_tick();
        n_tests++; if (state_o !== 3'(S_IDLE)) begin n_fail++; $display("FAIL refund_idle: got %0d want %0d", state_o, S_IDLE); end
    endtask

    task automatic test_ignore_and_exact();
        int seen_before;
        do_sel(3'd5);
        n_tests++; if (state_o !== 3'(S_IDLE)) begin n_fail++; $display("FAIL bad_type_ignored: got %0d want %0d", state_o, S_IDLE); end
        do_sel(3'd1);
        do_confirm();
        do_confirm();
        do_coin(COIN_10);
        cycle();
        n_tests++; if (state_o !== 3'(S_RELEASE) || change_o !== 8'd0) begin n_fail++; $display("FAIL exact_release: got state %0d change %0d want %0d 0", state_o, change_o, S_RELEASE); end
        repeat (5) do_tick();
        seen_before = coins_seen;
        n_tests++; if (state_o !== 3'(S_CHANGE)) begin n_fail++; $display("FAIL exact_change_entry: got %0d want %0d", state_o, S_CHANGE); end
        do_tick();
        n_tests++; if (state_o !== 3'(S_IDLE) || coins_seen !== seen_before) begin n_fail++; $display("FAIL exact_idle: got state %0d coins %0d want %0d %0d", state_o, coins_seen, S_IDLE, seen_before); end
    endtask

    task automatic test_timeout();
        do_sel(3'd2);
        do_confirm();
        do_confirm();
        do_coin(COIN_5); do_coin(COIN_1);
        n_tests++; if (paid_o !== 8'd6) begin n_fail++; $display("FAIL timeout_paid: got %0d want 6", paid_o); end
`ifdef TVM_TIMEOUT_EN
        repeat (3) do_tick();
        n_tests++; if (state_o !== 3'(S_PAYMENT) || timeouts_seen != 0) begin n_fail++; $display("FAIL timeout_early: got state %0d timeouts %0d want %0d 0", state_o, timeouts_seen, S_PAYMENT); end
        do_tick();
        push_refund(6);
        n_tests++; if (timeout_o !== 1'b1 || state_o !== 3'(S_CHANGE) || change_o !== 8'd6) begin n_fail++; $display("FAIL timeout_fire: got to %b state %0d change %0d want 1 %0d 6", timeout_o, state_o, change_o, S_CHANGE); end
        repeat (3) do_tick();
        n_tests++; if (state_o !== 3'(S_IDLE) || timeouts_seen != 1) begin n_fail++; $display("FAIL timeout_done: got state %0d timeouts %0d want %0d 1", state_o, timeouts_seen, S_IDLE); end
`else
        repeat (100) do_tick();
        n_tests++; if (state_o !== 3'(S_PAYMENT) || timeouts_seen != 0) begin n_fail++; $display("FAIL no_timeout: got state %0d timeouts %0d want %0d 0", state_o, timeouts_seen, S_PAYMENT); end
        do_cancel();
        push_refund(6);
        repeat (3) do_tick();
        n_tests++; if (state_o !== 3'(S_IDLE)) begin n_fail++; $display("FAIL no_timeout_refund: got %0d want %0d", state_o, S_IDLE); end
`endif
    endtask

    task automatic test_reset_mid_payment();
        do_sel(3'd2);
        do_confirm();
        do_confirm();
        do_coin(COIN_5); do_coin(COIN_1); do_coin(COIN_1);
        n_tests++; if (paid_o !== 8'd7) begin n_fail++; $display("FAIL midrst_paid: got %0d want 7", paid_o); end
        #3 rst = 1'b1;
        #1;
        n_tests++; if (state_o !== 3'(S_IDLE) || type_o !== 3'd0 || qty_o !== 4'd1) begin n_fail++; $display("FAIL midrst_ctrl: got state %0d type %0d qty %0d want %0d 0 1", state_o, type_o, qty_o, S_IDLE); end
        n_tests++; if ({total_o, paid_o, change_o} !== 24'd0) begin n_fail++; $display("FAIL midrst_money: got %0d/%0d/%0d want 0/0/0", total_o, paid_o, change_o); end
        n_tests++; if ({blink_o, release_o, change_valid, timeout_o} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %b want 0000", {blink_o, release_o, change_valid, timeout_o}); end
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_blink();
        test_purchase();
        test_amount();
        test_cancel_refund();
        test_ignore_and_exact();
        test_timeout();
        test_reset_mid_payment();
        repeat (2) cycle();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_queue_empty: got %0d pending want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
